// File: rtl/hack_alu_seq_if.sv
// Operand/result handshake bundle for hack_alu_seq.
// The master side is the producer/consumer (CPU datapath); slave is the ALU.
interface hack_alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             busy;

  modport master (
    output in_valid, x, y, ctrl, mode, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, busy
  );

  modport slave (
    input  in_valid, x, y, ctrl, mode, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, busy
  );
endinterface

// File: rtl/hack_alu_seq.sv
// Multi-cycle Hack ALU: single-cycle Hack ops plus iterative shift-add multiply
// and bit-serial shifts, with registered result/flags behind a valid/ready pair.
module hack_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hack_alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic             r_no;
  logic [WIDTH-1:0] r_out;
  logic             r_zr, r_ng, r_cy;

  logic             w_accept;
  logic [WIDTH-1:0] w_xp, w_yp, w_sum, w_hack, w_step, w_res, w_fin;
  logic             w_carry, w_no, w_cy_fin, w_load_done;
  logic [SHW-1:0]   w_amt;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_amt    = w_yp[SHW-1:0];

  always_comb begin
    w_xp = bus.ctrl[5] ? '0 : bus.x;
    if (bus.ctrl[4]) w_xp = ~w_xp;
    w_yp = bus.ctrl[3] ? '0 : bus.y;
    if (bus.ctrl[2]) w_yp = ~w_yp;
  end

  assign {w_carry, w_sum} = {1'b0, w_xp} + {1'b0, w_yp};
  assign w_hack = bus.ctrl[1] ? w_sum : (w_xp & w_yp);

  always_comb begin
    w_step = r_acc;
    unique case (r_mode)
      2'b01:   w_step = r_mp[0] ? r_acc + r_mc : r_acc;
      2'b10:   w_step = {r_acc[WIDTH-2:0], 1'b0};
      2'b11:   w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_step = r_acc;
    endcase
  end

  // Results land either straight from the accept cycle (Hack op, zero shift)
  // or from the final iteration step, so both sources feed one output mux.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_res    = (bus.mode == 2'b00) ? w_hack : w_xp;
      w_no     = bus.ctrl[0];
      w_cy_fin = (bus.mode == 2'b00) && bus.ctrl[1] && w_carry;
    end else begin
      w_res    = w_step;
      w_no     = r_no;
      w_cy_fin = 1'b0;
    end
    w_fin = w_no ? ~w_res : w_res;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept) begin
          if ((bus.mode == 2'b00) || (bus.mode[1] && (w_amt == '0)))
            w_state_nxt = S_DONE;
          else
            w_state_nxt = S_EXEC;
        end
      S_EXEC:
        if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:
        if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_mc   <= '0;
      r_mp   <= '0;
      r_cnt  <= '0;
      r_mode <= '0;
      r_no   <= 1'b0;
      r_out  <= '0;
      r_zr   <= 1'b0;
      r_ng   <= 1'b0;
      r_cy   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_mode <= bus.mode;
        r_no   <= bus.ctrl[0];
        r_mc   <= w_xp;
        r_mp   <= w_yp;
        r_acc  <= (bus.mode == 2'b01) ? '0 : w_xp;
        r_cnt  <= (bus.mode == 2'b01) ? CW'(WIDTH) : CW'(w_amt);
      end else if (r_state == S_EXEC) begin
        r_acc <= w_step;
        r_mc  <= {r_mc[WIDTH-2:0], 1'b0};
        r_mp  <= {1'b0, r_mp[WIDTH-1:1]};
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_load_done) begin
        r_out <= w_fin;
        r_zr  <= (w_fin == '0);
        r_ng  <= w_fin[WIDTH-1];
        r_cy  <= w_cy_fin;
      end
    end
  end

  assign bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out       = r_out;
  assign bus.zr        = r_zr;
  assign bus.ng        = r_ng;
  assign bus.cy        = r_cy;
endmodule

// File: tb/tb_hack_alu_seq.sv
// Directed bench for hack_alu_seq (WIDTH=16): vector table plus backpressure
// and mid-operation reset sequences.
module tb_hack_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hack_alu_seq_if #(.WIDTH(16)) bus ();

  hack_alu_seq #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctrl;
    logic [1:0]  mode;
    logic [15:0] eout;
    logic        ezr;
    logic        eng;
    logic        ecy;
    int          elat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic [5:0] ctrl, input logic [1:0] mode);
    int n = 0;
    bus.x = x; bus.y = y; bus.ctrl = ctrl; bus.mode = mode;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      errors++; checks++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      busy_ok &= bus.busy;
      @(posedge clk); #1; lat++;
    end
    busy_ok &= bus.busy;
  endtask

  initial begin
    int   lat;
    logic bok;

    vecs[0]  = '{16'hAAAA, 16'h5555, 6'b000010, 2'b00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{16'hAAAA, 16'h5555, 6'b010101, 2'b00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{16'h1234, 16'h5678, 6'b111111, 2'b00, 16'h0001, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{16'hFFFF, 16'h0001, 6'b000010, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1};
    vecs[4]  = '{16'h0005, 16'h0003, 6'b010011, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{16'hF0F0, 16'hFF00, 6'b000000, 2'b00, 16'hF000, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{16'h0007, 16'h0006, 6'b000000, 2'b01, 16'h002A, 1'b0, 1'b0, 1'b0, 17};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 6'b000000, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0, 17};
    vecs[8]  = '{16'h0003, 16'h0004, 6'b000001, 2'b01, 16'hFFF3, 1'b0, 1'b1, 1'b0, 17};
    vecs[9]  = '{16'h0001, 16'h000F, 6'b000000, 2'b10, 16'h8000, 1'b0, 1'b1, 1'b0, 16};
    vecs[10] = '{16'h8000, 16'h0003, 6'b000000, 2'b11, 16'hF000, 1'b0, 1'b1, 1'b0, 4};
    vecs[11] = '{16'h1234, 16'h0000, 6'b000000, 2'b10, 16'h1234, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{16'h8001, 16'h0010, 6'b000000, 2'b11, 16'h8001, 1'b0, 1'b1, 1'b0, 1};
    vecs[13] = '{16'h1234, 16'h0005, 6'b100000, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0, 6};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.x = '0; bus.y = '0; bus.ctrl = '0; bus.mode = '0;

    #2;
    chk("rst_out", bus.out, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_flags", {bus.out_valid, bus.busy, bus.zr, bus.ng, bus.cy}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].ctrl, vecs[i].mode);
      wait_result(lat, bok);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_out", i), bus.out, vecs[i].eout);
      chk($sformatf("v%0d_flags", i), {bus.zr, bus.ng, bus.cy},
          {vecs[i].ezr, vecs[i].eng, vecs[i].ecy});
      chk($sformatf("v%0d_busy", i), bok, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_xfer", i), {bus.out_valid, bus.in_ready}, 2'b01);
    end

    // Backpressure: result must hold while out_ready is low, new commands ignored.
    bus.out_ready = 1'b0;
    issue(16'h0005, 16'h0003, 6'b000010, 2'b00);
    wait_result(lat, bok);
    chk("bp_lat", lat, 1);
    bus.x = 16'hFFFF; bus.y = 16'hFFFF; bus.ctrl = 6'b000010; bus.mode = 2'b00;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c),
          {bus.out, bus.zr, bus.ng, bus.cy, bus.out_valid, bus.in_ready},
          {16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    issue(16'h00FF, 16'h0F00, 6'b000010, 2'b00);
    wait_result(lat, bok);
    chk("bp_next_out", bus.out, 16'h0FFF);
    chk("bp_next_lat", lat, 1);
    @(posedge clk); #1;

    // Asynchronous reset during cycle 8 of a multiply.
    issue(16'h0009, 16'h0009, 6'b000000, 2'b01);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_out", bus.out, 0);
    chk("mrst_flags", {bus.out_valid, bus.busy, bus.in_ready, bus.zr, bus.ng, bus.cy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_rel", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    issue(16'h0003, 16'h0004, 6'b000000, 2'b01);
    wait_result(lat, bok);
    chk("mrst_mul_out", bus.out, 16'h000C);
    chk("mrst_mul_lat", lat, 17);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time got 200000 expected less");
    $fatal(1);
  end
endmodule

// File: doc/hack_alu_seq.md
# hack_alu_seq

Parametrised, multi-cycle successor to the Hack ALU. It keeps the six Hack control bits (zx, nx, zy, ny, f, no) and the zr/ng flags, and adds three things: a WIDTH parameter, a carry flag, and iterative multiply and shift modes. Operands enter and results leave through valid/ready handshakes, so the block sits between the CPU decode stage and the D/A/M writeback path and can stall the datapath while an iterative operation runs.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- SHW, $clog2(WIDTH), derived width of the shift-amount field; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block can accept a command.
- x  in  WIDTH  operand X.
- y  in  WIDTH  operand Y.
- ctrl  in  6  {zx,nx,zy,ny,f,no}, with zx as bit 5.
- mode  in  2  00 Hack op, 01 multiply, 10 logical shift left, 11 arithmetic shift right.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- zr  out  1  out == 0.
- ng  out  1  out[WIDTH-1].
- cy  out  1  carry out of the adder.
- busy  out  1  state is not IDLE.

## Operation
- Accept: a command is taken when in_valid && in_ready. x, y, ctrl and mode are captured that cycle; later changes on the inputs have no effect on the command in flight.
- Operand preprocessing, applied in every mode:
  - xp = zx ? 0 : x, then xp = nx ? ~xp : xp.
  - yp is formed the same way from y using zy and ny.
- Result by mode:
  - mode 00: r = f ? xp+yp : xp&yp. cy = carry out of xp+yp when f=1, else 0.
  - mode 01: r = low WIDTH bits of xp*yp, computed by shift-add, one multiplier bit per cycle, for WIDTH cycles. cy = 0.
  - mode 10: r = xp << yp[SHW-1:0], one bit per cycle. cy = 0.
  - mode 11: r = xp >>> yp[SHW-1:0], one bit per cycle, with the sign bit replicated. cy = 0.
- Output: out = no ? ~r : r in all modes. zr and ng are computed from final out. cy is not affected by no.
- States:
  - IDLE → DONE on accept when mode = 00, or when mode = 1x with shift amount 0.
  - IDLE → EXEC on any other accept. The iteration counter loads WIDTH for multiply or the shift amount for shifts.
  - EXEC decrements the counter each cycle and moves to DONE on the cycle the counter reaches 1.
  - DONE → IDLE on out_valid && out_ready.
- Handshake signals:
  - in_ready = rst_n && state == IDLE.
  - out_valid = state == DONE.
  - busy = state != IDLE.
- Backpressure: while in DONE with out_ready low, out, zr, ng and cy hold stable.
- Reset (rst_n low), asynchronous at any point, including mid-EXEC:
  - State goes to IDLE and any command in flight is discarded.
  - out = 0, zr = 0, ng = 0, cy = 0, out_valid = 0, busy = 0, in_ready = 0.
  - in_ready returns to 1 in the first cycle after rst_n deasserts.
- Arithmetic: all arithmetic is modulo 2^WIDTH. Overflow is not flagged apart from cy in mode 00.

## Timing
- Latency is counted from the accept edge to the first cycle with out_valid high:
  - mode 00: 1 cycle.
  - multiply: WIDTH+1 cycles.
  - shifts: k+1 cycles for shift amount k, so k = 0 gives 1 cycle.
- out, zr, ng and cy are registered. They update on the edge that enters DONE and are otherwise unchanged.
- There is no accept while in DONE, so the minimum issue interval is 2 cycles (accept, then DONE with out_ready high).
- If out_ready is already high when DONE is entered, the result transfers in that first DONE cycle and in_ready rises the next cycle.
- in_valid asserted while in_ready is low is ignored. The producer must keep in_valid and its data stable until accepted.

## Test plan
- **Hack op (WIDTH=16).** x=0xAAAA, y=0x5555, ctrl=000010, mode=00 → out=0xFFFF, ng=1, zr=0, cy=0, out_valid one cycle after accept. Also cover ctrl=010101 (x|y) → 0xFFFF and ctrl=111111 → out=1.
- **Carry/zero.** x=0xFFFF, y=0x0001, ctrl=000010 → out=0x0000, zr=1, cy=1. Also cover ctrl=010011 (x-y) with x=5, y=3 → out=2.
- **Multiply.** x=7, y=6, mode=01, ctrl=000000 → out=42 after exactly 17 cycles, busy high throughout. Also cover x=0xFFFF, y=0xFFFF → out=0x0001.
- **Shifts.** x=0x0001, y=15, mode=10 → out=0x8000 at latency 16. x=0x8000, y=3, mode=11 → out=0xF000 at latency 4. y=0 (shift amount 0) → out=x at latency 1.
- **Backpressure.** Hold out_ready low for 5 cycles in DONE → out and flags stable, in_ready=0, a concurrent in_valid is ignored. Raise out_ready → IDLE next cycle, and the next command is accepted correctly.
- **Reset mid-operation.** Pull rst_n low during cycle 8 of a multiply → all outputs 0 immediately. After release: in_ready=1, no stale out_valid, and a following x=3, y=4 multiply returns 12.
